gx4000_cpr_loader: RTL and testbench

- Parses a CPR cartridge image (RIFF/"AMS!" container) streamed over the ioctl download bus during cartridge load.
- Writes each "cbNN" chunk payload into the cartridge ROM region of SDRAM at bank NN × 16 KB.
- Sits directly upstream of the GX4000 cartridge bank mapper and fills the ROM banks that the mapper later selects.
- Reports bank presence and load status to the mapper and the boot logic.

---
 rtl/gx4000_cpr_loader_if.sv | 28 ++
 rtl/gx4000_cpr_loader.sv | 181 ++++++++++++++++++
 tb/tb_gx4000_cpr_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/gx4000_cpr_loader_if.sv
// Download-side and SDRAM-side signals of the CPR loader, plus the status it reports.
// The master modport is the loader's view; the slave modport is the downloader/SDRAM/mapper side.
interface gx4000_cpr_loader_if;
   logic        cart_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [22:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_wr;
   logic        mem_ready;
   logic [31:0] bank_present;
   logic [5:0]  bank_count;
   logic        load_done;
   logic        load_error;

   modport master (
      input  cart_download, ioctl_wr, ioctl_dout, mem_ready,
      output ioctl_wait, mem_addr, mem_din, mem_wr,
             bank_present, bank_count, load_done, load_error
   );

   modport slave (
      output cart_download, ioctl_wr, ioctl_dout, mem_ready,
      input  ioctl_wait, mem_addr, mem_din, mem_wr,
             bank_present, bank_count, load_done, load_error
   );
endinterface

// File: rtl/gx4000_cpr_loader.sv
// Parses a streamed CPR (RIFF "AMS!") image and writes each cbNN chunk into the
// cartridge ROM area of SDRAM, one 16 KB bank per chunk number.
module gx4000_cpr_loader #(
   parameter logic [22:0] CART_BASE = 23'h400000,
   parameter int          MAX_BANK  = 31
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   gx4000_cpr_loader_if.master  bus
);
   typedef enum logic [2:0] {HDR, ID, LEN, DATA, SKIP, PAD, DONE, ERR} state_t;

   localparam logic [6:0] MAX_NN = 7'(MAX_BANK);

   state_t      state;
   logic        dl_d;
   logic [3:0]  cnt;
   logic [31:0] id_q;
   logic [31:0] len_q;
   logic [31:0] rem;
   logic [14:0] off;
   logic [4:0]  nn;
   logic        odd;
   logic        chunk_seen;
   logic [22:0] mem_addr_q;
   logic [7:0]  mem_din_q;
   logic        mem_wr_q;
   logic [31:0] bank_present_q;
   logic [5:0]  bank_count_q;
   logic        load_done_q;
   logic        load_error_q;

   logic        dl_rise, dl_fall, byte_in;
   logic [7:0]  hdr_exp;
   logic        hdr_any;
   logic [3:0]  d1, d0;
   logic [6:0]  nn_full;
   logic        id_ok;
   logic [31:0] len_full;

   assign dl_rise  = bus.cart_download & ~dl_d;
   assign dl_fall  = ~bus.cart_download & dl_d;
   // Bytes strobed while a write is still outstanding violate the wait handshake and are dropped.
   assign byte_in  = bus.ioctl_wr & ~mem_wr_q & bus.cart_download;
   assign len_full = {bus.ioctl_dout, len_q[31:8]};

   assign d1      = 4'(id_q[15:8] - 8'h30);
   assign d0      = 4'(id_q[7:0] - 8'h30);
   assign nn_full = 7'(d1) * 7'd10 + 7'(d0);
   assign id_ok   = (id_q[31:24] == "c") && (id_q[23:16] == "b") &&
                    (id_q[15:8] >= "0") && (id_q[15:8] <= "9") &&
                    (id_q[7:0] >= "0") && (id_q[7:0] <= "9") &&
                    (nn_full <= MAX_NN);

   always_comb begin
      hdr_exp = 8'h00;
      hdr_any = 1'b0;
      case (cnt)
         4'd0:  hdr_exp = "R";
         4'd1:  hdr_exp = "I";
         4'd2:  hdr_exp = "F";
         4'd3:  hdr_exp = "F";
         4'd8:  hdr_exp = "A";
         4'd9:  hdr_exp = "M";
         4'd10: hdr_exp = "S";
         4'd11: hdr_exp = "!";
         default: hdr_any = 1'b1;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state          <= HDR;
         dl_d           <= 1'b0;
         cnt            <= '0;
         id_q           <= '0;
         len_q          <= '0;
         rem            <= '0;
         off            <= '0;
         nn             <= '0;
         odd            <= 1'b0;
         chunk_seen     <= 1'b0;
         mem_addr_q     <= '0;
         mem_din_q      <= '0;
         mem_wr_q       <= 1'b0;
         bank_present_q <= '0;
         bank_count_q   <= '0;
         load_done_q    <= 1'b0;
         load_error_q   <= 1'b0;
      end else begin
         dl_d <= bus.cart_download;
         if (mem_wr_q && bus.mem_ready) mem_wr_q <= 1'b0;

         if (dl_rise) begin
            state          <= HDR;
            cnt            <= '0;
            rem            <= '0;
            off            <= '0;
            chunk_seen     <= 1'b0;
            bank_present_q <= '0;
            bank_count_q   <= '0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
         end else if (dl_fall) begin
            // Only a file that stops exactly on a chunk boundary counts as complete.
            if (state == ID && cnt == 4'd0 && chunk_seen) begin
               state       <= DONE;
               load_done_q <= 1'b1;
            end else if (state != DONE) begin
               state        <= ERR;
               load_error_q <= 1'b1;
            end
         end else if (byte_in) begin
            case (state)
               HDR: begin
                  if (!hdr_any && bus.ioctl_dout != hdr_exp) begin
                     state        <= ERR;
                     load_error_q <= 1'b1;
                  end else if (cnt == 4'd11) begin
                     state <= ID;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               ID: begin
                  id_q <= {id_q[23:0], bus.ioctl_dout};
                  if (cnt == 4'd3) begin
                     state <= LEN;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               LEN: begin
                  len_q <= len_full;
                  if (cnt == 4'd3) begin
                     cnt        <= '0;
                     chunk_seen <= 1'b1;
                     rem        <= len_full;
                     odd        <= len_full[0];
                     off        <= '0;
                     nn         <= nn_full[4:0];
                     if (len_full == 32'd0) state <= ID;
                     else if (id_ok)        state <= DATA;
                     else                   state <= SKIP;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               DATA, SKIP: begin
                  // off saturates at 16384 so oversized chunks keep consuming without writes.
                  if (state == DATA && !off[14]) begin
                     mem_addr_q <= CART_BASE + {4'b0, nn, off[13:0]};
                     mem_din_q  <= bus.ioctl_dout;
                     mem_wr_q   <= 1'b1;
                     off        <= off + 15'd1;
                     if (!bank_present_q[nn]) begin
                        bank_present_q[nn] <= 1'b1;
                        bank_count_q       <= bank_count_q + 6'd1;
                     end
                  end
                  rem <= rem - 32'd1;
                  if (rem == 32'd1) state <= odd ? PAD : ID;
               end
               PAD:     state <= ID;
               default: ;
            endcase
         end
      end
   end

   assign bus.ioctl_wait   = mem_wr_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_din      = mem_din_q;
   assign bus.mem_wr       = mem_wr_q;
   assign bus.bank_present = bank_present_q;
   assign bus.bank_count   = bank_count_q;
   assign bus.load_done    = load_done_q;
   assign bus.load_error   = load_error_q;
endmodule

// File: tb/tb_gx4000_cpr_loader.sv
// Directed CPR streams; expected SDRAM writes go into a queue that a monitor drains
// as the loader's writes are accepted, while status outputs are compared inline.
module tb_gx4000_cpr_loader;
   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   logic [30:0] exp_q[$];

   gx4000_cpr_loader_if bus ();

   gx4000_cpr_loader dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));

   always #5 clk_sys = ~clk_sys;

   // Scoreboard monitor: a write is accepted at the next edge whenever mem_wr & mem_ready.
   always @(negedge clk_sys) begin
      if (!reset && bus.mem_wr && bus.mem_ready) begin
         logic [30:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_din);
         end else begin
            e = exp_q.pop_front();
            if ({bus.mem_addr, bus.mem_din} !== e) begin
               errors++;
               $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                        bus.mem_addr, bus.mem_din, e[30:8], e[7:0]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (bus.ioctl_wait && n < 1000) begin
         @(posedge clk_sys); #1;
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL wait_timeout ioctl_wait stuck 1 want 0");
      end
      bus.ioctl_dout = b;
      bus.ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);   // ASCII order, first char first
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic send_chunk(input logic [31:0] id, input logic [31:0] len);
      send_word(id);
      for (int i = 0; i < 4; i++) send_byte(len[i*8 +: 8]);
   endtask

   task automatic send_hdr();
      send_word("RIFF");
      send_word(32'h12345678);
      send_word("AMS!");
   endtask

   task automatic expw(input logic [22:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic start_dl();
      bus.cart_download = 1'b1;
      @(posedge clk_sys); #1;
   endtask

   task automatic end_dl();
      bus.cart_download = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic status(input string nm, input logic [31:0] bp, input logic [5:0] bc,
                         input logic done, input logic err);
      chk({nm, "_bank_present"}, bus.bank_present, bp);
      chk({nm, "_bank_count"}, 32'(bus.bank_count), 32'(bc));
      chk({nm, "_load_done"}, 32'(bus.load_done), 32'(done));
      chk({nm, "_load_error"}, 32'(bus.load_error), 32'(err));
   endtask

   initial begin
      bus.cart_download = 1'b0;
      bus.ioctl_wr      = 1'b0;
      bus.ioctl_dout    = 8'h00;
      bus.mem_ready     = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      status("reset", 32'h0, 6'd0, 1'b0, 1'b0);
      chk("reset_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("reset_ioctl_wait", 32'(bus.ioctl_wait), 32'd0);

      // Valid two-chunk file
      start_dl();
      send_hdr();
      send_chunk("cb00", 32'd4);
      expw(23'h400000, 8'hAA); send_byte(8'hAA);
      expw(23'h400001, 8'hBB); send_byte(8'hBB);
      expw(23'h400002, 8'hCC); send_byte(8'hCC);
      expw(23'h400003, 8'hDD); send_byte(8'hDD);
      send_chunk("cb01", 32'd2);
      expw(23'h404000, 8'h11); send_byte(8'h11);
      expw(23'h404001, 8'h22); send_byte(8'h22);
      end_dl();
      status("valid", 32'h3, 6'd2, 1'b1, 1'b0);

      // Odd length, pad bytes, unknown chunk and an empty chunk
      start_dl();
      status("restart", 32'h0, 6'd0, 1'b0, 1'b0);
      send_hdr();
      send_chunk("cb02", 32'd3);
      expw(23'h408000, 8'h01); send_byte(8'h01);
      expw(23'h408001, 8'h02); send_byte(8'h02);
      expw(23'h408002, 8'h03); send_byte(8'h03);
      send_byte(8'hEE);
      send_chunk("fmt ", 32'd6);
      for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
      send_chunk("cb04", 32'd0);
      send_chunk("cb03", 32'd1);
      expw(23'h40C000, 8'h55); send_byte(8'h55);
      send_byte(8'h77);
      end_dl();
      status("odd", 32'hC, 6'd2, 1'b1, 1'b0);

      // Bad header: error right after byte 3, rest of stream ignored
      start_dl();
      send_word("RIFX");
      chk("badhdr_err_early", 32'(bus.load_error), 32'd1);
      send_word(32'h0);
      send_word("AMS!");
      send_chunk("cb00", 32'd2);
      send_byte(8'h99);
      send_byte(8'h98);
      end_dl();
      status("badhdr", 32'h0, 6'd0, 1'b0, 1'b1);

      // Oversized chunk, then a normal one
      start_dl();
      send_hdr();
      send_chunk("cb05", 32'd16386);
      for (int i = 0; i < 16386; i++) begin
         if (i < 16384) expw(23'h414000 + 23'(i), 8'(i));
         send_byte(8'(i));
      end
      send_chunk("cb06", 32'd2);
      expw(23'h418000, 8'h5A); send_byte(8'h5A);
      expw(23'h418001, 8'hA5); send_byte(8'hA5);
      end_dl();
      status("oversize", 32'h60, 6'd2, 1'b1, 1'b0);

      // Backpressure: mem_ready low for 5 cycles after the first data byte
      start_dl();
      send_hdr();
      send_chunk("cb07", 32'd2);
      bus.mem_ready = 1'b0;
      expw(23'h41C000, 8'h9A); send_byte(8'h9A);
      for (int i = 0; i < 5; i++) begin
         chk("bp_mem_wr", 32'(bus.mem_wr), 32'd1);
         chk("bp_wait", 32'(bus.ioctl_wait), 32'd1);
         chk("bp_addr", 32'(bus.mem_addr), 32'h41C000);
         chk("bp_din", 32'(bus.mem_din), 32'h9A);
         if (i < 4) begin @(posedge clk_sys); #1; end
      end
      bus.mem_ready = 1'b1;
      @(posedge clk_sys); #1;
      chk("bp_released", 32'(bus.mem_wr), 32'd0);
      expw(23'h41C001, 8'h9B); send_byte(8'h9B);
      end_dl();
      status("bp", 32'h80, 6'd1, 1'b1, 1'b0);

      // Truncated in the middle of DATA
      start_dl();
      send_hdr();
      send_chunk("cb08", 32'd4);
      expw(23'h420000, 8'h31); send_byte(8'h31);
      expw(23'h420001, 8'h32); send_byte(8'h32);
      end_dl();
      status("trunc", 32'h100, 6'd1, 1'b0, 1'b1);

      // Reset while a write is pending
      start_dl();
      send_hdr();
      send_chunk("cb09", 32'd4);
      bus.mem_ready = 1'b0;
      send_byte(8'h44);
      chk("rst_pre_mem_wr", 32'(bus.mem_wr), 32'd1);
      chk("rst_pre_bank", bus.bank_present, 32'h200);
      bus.cart_download = 1'b0;
      reset = 1'b1;
      @(posedge clk_sys); #1;
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
      status("rst", 32'h0, 6'd0, 1'b0, 1'b0);
      reset = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout sim time exceeded want finish");
      $fatal(1);
   end
endmodule
